store_sequencer: RTL and testbench
==================================

# store_sequencer

Multicycle store controller sitting between the control unit and data memory, directly around the store-size merge stage. For sb/sh it performs a read-modify-write: reads the target word into its MDR register, which feeds the merge stage as `Data_MDR`, drives `SSCtrl`, captures the merged word, and writes it back. For sw it skips the read. The control unit sees one start/done transaction per store.

## Interface
Parameters:
- `MEM_LAT`, default 1: data-memory read latency in cycles, legal range 1..7.
- `ADDR_W`, default 32: address width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: store request. Sampled only in IDLE.
- `size` in 2: store width. 01 = word, 10 = half, 11 = byte, 00 = no-op.
- `addr` in ADDR_W: store address. Latched on accept.
- `mem_rdata` in 32: data-memory read data.
- `merged_data` in 32: merged word returned by the store-size stage (`Data_out`).
- `mem_addr` out ADDR_W: memory address (latched `addr`).
- `mem_wr` out 1: memory write strobe.
- `mem_wdata` out 32: registered write data.
- `mdr_q` out 32: MDR register, drives `Data_MDR` of the merge stage.
- `ss_ctrl` out 2: drives `SSCtrl` of the merge stage.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `align_err` out 1: one-cycle misalignment pulse, coincident with `done`.

Decided: one clock `clk`; reset `reset` is synchronous and active-high.

## Operation
- States: IDLE, READ, MERGE, WRITE, DONE.
- IDLE, with `start`=1:
  - latch `addr`, and latch `size` into `ss_ctrl`;
  - size 01 → MERGE;
  - size 10/11 → READ, with the wait counter loaded to MEM_LAT;
  - size 00 → DONE, with no memory access.
- READ: `mem_addr` = latched addr, `mem_wr`=0. The counter decrements each cycle. On the cycle the counter reaches 1, `mdr_q` <= `mem_rdata`, then the FSM moves to MERGE.
- MERGE: `ss_ctrl` and `mdr_q` are stable, so `merged_data` settles combinationally. `mem_wdata` <= `merged_data`, then the FSM moves to WRITE.
- WRITE: `mem_wr`=1 for exactly one cycle, then the FSM moves to DONE.
- DONE: `done`=1, then the FSM moves to IDLE.
- `start` while `busy`: ignored, not queued.
- `ss_ctrl` holds the latched size until the next accept, so it is never 00-undefined downstream.
- 00 is passed through with no write.
- Reset values:
  - state IDLE;
  - `mem_wr`, `done`, `busy`, `align_err` = 0;
  - `mdr_q`, `mem_wdata`, `mem_addr` = 0;
  - `ss_ctrl` = 01.
- Reset mid-operation: the next edge returns the FSM to IDLE. `mem_wr` is 0 from that edge, so no partial or late write occurs. Any pending `done` is dropped.

## Timing
- Start is accepted at cycle 0.
- Word store: MERGE at cycle 1, `mem_wr` at cycle 2, `done` at cycle 3.
- Half/byte store:
  - READ occupies cycles 1..MEM_LAT;
  - MERGE at MEM_LAT+1;
  - `mem_wr` at MEM_LAT+2;
  - `done` at MEM_LAT+3.
- No-op (size 00) or misaligned store: `done` at cycle 1.
- Back-to-back: a new `start` is accepted in the cycle after `done`, the first IDLE cycle.
- All outputs are registered, except `busy`, which is decoded from state.

## Configuration
- `STORE_ALIGN_CHECK_EN` defined:
  - On accept, a misaligned store goes directly to DONE with no memory access, and `align_err`=1 alongside `done`.
  - Misaligned means: half with addr[0]=1, or word with addr[1:0]≠00.
- Not defined: `align_err` is tied 0, and every address proceeds normally.

## Structure
- Shared package `cpu_mem_pkg` holds:
  - the size encodings `SS_NONE`, `SS_WORD`, `SS_HALF`, `SS_BYTE` (shared with the merge and load-size stages);
  - the FSM state enum.
- One sub-module: `mem_wait_counter`, a 3-bit loadable down-counter with a `last` flag, reusable by the load sequencer.

## Test plan
- Word, MEM_LAT=1: addr=0x40, B=0xDEADBEEF. Required: `mem_wr` at cycle 2 with `mem_wdata`=0xDEADBEEF, no read cycle, `done` at cycle 3.
- Byte, MEM_LAT=2: memory word 0x11223344, B low byte 0xAA. Required: `mdr_q`=0x11223344 after cycle 2, write 0x112233AA at cycle 4, `done` at cycle 5.
- Half, MEM_LAT=1: memory word 0x11223344, B=0x0000BEEF. Required: write 0x1122BEEF, `ss_ctrl`=10 throughout busy.
- `start` pulsed during READ, then `reset` asserted during MERGE. Required: second start ignored, no `mem_wr` after reset, outputs at reset values.
- With `STORE_ALIGN_CHECK_EN`: half store at addr 0x41. Required: `done`=`align_err`=1 at cycle 1, `mem_wr` never asserted. Without the macro: write occurs at cycle MEM_LAT+2.
- Size 00: `done` at cycle 1, no `mem_wr`. Then an immediate byte store is accepted on the next cycle.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared size encodings and store FSM states for the merge, load-size and store stages.
package cpu_mem_pkg;

  localparam logic [1:0] SS_NONE = 2'b00;
  localparam logic [1:0] SS_WORD = 2'b01;
  localparam logic [1:0] SS_HALF = 2'b10;
  localparam logic [1:0] SS_BYTE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } st_e;

  // Half needs addr[0]=0, word needs addr[1:0]=00; bytes are always aligned.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a_lo);
    return ((sz == SS_HALF) && a_lo[0]) || ((sz == SS_WORD) && (a_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 3-bit down-counter; last flags the final wait cycle (count == 1).
module mem_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       en,
  output logic       last
);

  logic [2:0] count;

  always_ff @(posedge clk) begin
    if (reset)                    count <= 3'd0;
    else if (load)                count <= load_val;
    else if (en && count != 3'd0) count <= count - 3'd1;
  end

  assign last = (count == 3'd1);

endmodule

// File: rtl/store_sequencer.sv
// Multicycle store controller: read-modify-write for sb/sh, direct write for sw.
// Optional STORE_ALIGN_CHECK_EN: misaligned stores finish at once with align_err.
module store_sequencer
  import cpu_mem_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       mem_rdata,
  input  logic [31:0]       merged_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       mdr_q,
  output logic [1:0]        ss_ctrl,
  output logic              busy,
  output logic              done,
  output logic              align_err
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  st_e  state;
  logic accept;
  logic mis;
  logic last;

`ifdef STORE_ALIGN_CHECK_EN
  assign mis = misaligned(size, addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign accept = (state == ST_IDLE) && start;
  assign busy   = (state != ST_IDLE);

  mem_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (LAT),
    .en       (state == ST_READ),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      align_err <= 1'b0;
      mdr_q     <= 32'd0;
      mem_wdata <= 32'd0;
      mem_addr  <= '0;
      ss_ctrl   <= SS_WORD;
    end else begin
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      align_err <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          mem_addr <= addr;
          ss_ctrl  <= size;
          if (size == SS_NONE || mis) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            align_err <= mis;
          end else if (size == SS_WORD) begin
            state <= ST_MERGE;
          end else begin
            state <= ST_READ;
          end
        end
        ST_READ: if (last) begin
          mdr_q <= mem_rdata;
          state <= ST_MERGE;
        end
        // mdr_q and ss_ctrl are stable here, so merged_data has settled.
        ST_MERGE: begin
          mem_wdata <= merged_data;
          mem_wr    <= 1'b1;
          state     <= ST_WRITE;
        end
        ST_WRITE: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Self-checking bench for store_sequencer: directed scenarios plus random stores vs. a word-level model.
module tb_store_sequencer;

  localparam int MEM_LAT = 2;
  localparam int ADDR_W  = 32;

  typedef struct {
    int          wr_cyc;
    int          wr_n;
    logic [31:0] wdata;
    logic [31:0] waddr;
    int          done_cyc;
    logic        ae;
    logic        ss_bad;
    logic [31:0] mdr;
    logic        idle_after;
  } obs_t;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       mem_rdata, merged_data, bdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr, busy, done, align_err;
  logic [31:0]       mem_wdata, mdr_q;
  logic [1:0]        ss_ctrl;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  store_sequencer #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
    .mem_rdata(mem_rdata), .merged_data(merged_data), .mem_addr(mem_addr),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mdr_q(mdr_q), .ss_ctrl(ss_ctrl),
    .busy(busy), .done(done), .align_err(align_err)
  );

  // Bench-side memory and store-size merge stage.
  assign mem_rdata = mem[mem_addr[5:2]];
  always_comb begin
    merged_data = mdr_q;
    case (ss_ctrl)
      2'b01:   merged_data = bdata;
      2'b10:   merged_data = {mdr_q[31:16], bdata[15:0]};
      2'b11:   merged_data = {mdr_q[31:8], bdata[7:0]};
      default: merged_data = mdr_q;
    endcase
  end

  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef STORE_ALIGN_CHECK_EN
    return (sz == 2'b10 && a[0]) || (sz == 2'b01 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_word(input logic [1:0] sz, input logic [31:0] old, input logic [31:0] b);
    case (sz)
      2'b01:   return b;
      2'b10:   return {old[31:16], b[15:0]};
      2'b11:   return {old[31:8], b[7:0]};
      default: return old;
    endcase
  endfunction

  // Cycle at which done is expected; write cycle is one earlier when a write happens.
  function automatic int model_done(input logic [1:0] sz, input logic mis);
    if (sz == 2'b00 || mis) return 1;
    if (sz == 2'b01)        return 3;
    return MEM_LAT + 3;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    mem[a[5:2]] = v;
    ref_mem[a[5:2]] = v;
  endtask

  // Drives one store from the current (idle) cycle and records what the DUT does.
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] b, output obs_t o);
    o.wr_cyc = -1; o.wr_n = 0; o.wdata = 0; o.waddr = 0; o.done_cyc = -1;
    o.ae = 0; o.ss_bad = 0; o.mdr = 0; o.idle_after = 0;
    size = sz; addr = a; bdata = b; start = 1'b1;
    for (int c = 1; c <= 30 && o.done_cyc < 0; c++) begin
      tick();
      start = 1'b0; size = 2'($urandom); addr = $urandom;
      if (busy && sz != 2'b00 && ss_ctrl !== sz) o.ss_bad = 1;
      if (c == MEM_LAT + 1) o.mdr = mdr_q;
      if (mem_wr) begin
        o.wr_n++; o.wr_cyc = c; o.wdata = mem_wdata; o.waddr = mem_addr;
        mem[mem_addr[5:2]] = mem_wdata;
      end
      if (done) begin o.done_cyc = c; o.ae = align_err; end
    end
    tick();
    o.idle_after = !busy && !done && !mem_wr;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; size = 2'b00; addr = '0; bdata = '0;
    tick(); tick();
    n_checks++;
    if ({mem_wr, done, busy, align_err} !== 4'b0 || mdr_q !== 0 || mem_wdata !== 0 || mem_addr !== 0 || ss_ctrl !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_values: got wr=%b done=%b busy=%b ae=%b mdr=%h wd=%h ma=%h ss=%b, need all 0 and ss=01",
               mem_wr, done, busy, align_err, mdr_q, mem_wdata, mem_addr, ss_ctrl);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_word();
    obs_t o;
    do_store(2'b01, 32'h40, 32'hDEADBEEF, o);
    n_checks++; if (o.wr_cyc !== 2 || o.wr_n !== 1) begin n_fail++; $display("FAIL word_wr_cycle: got cyc=%0d n=%0d, need cyc=2 n=1", o.wr_cyc, o.wr_n); end
    n_checks++; if (o.wdata !== 32'hDEADBEEF || o.waddr !== 32'h40) begin n_fail++; $display("FAIL word_wdata: got %h@%h, need deadbeef@40", o.wdata, o.waddr); end
    n_checks++; if (o.done_cyc !== 3) begin n_fail++; $display("FAIL word_done: got cycle %0d, need 3", o.done_cyc); end
    n_checks++; if (o.idle_after !== 1'b1) begin n_fail++; $display("FAIL word_idle_after: got %b, need 1", o.idle_after); end
    ref_mem[4'h0] = ref_mem[4'h0]; ref_mem[32'h40 >> 2 & 15] = 32'hDEADBEEF;
  endtask

  task automatic test_byte();
    obs_t o;
    poke(32'h48, 32'h11223344);
    do_store(2'b11, 32'h48, 32'h000000AA, o);
    n_checks++; if (o.mdr !== 32'h11223344) begin n_fail++; $display("FAIL byte_mdr: got %h, need 11223344", o.mdr); end
    n_checks++; if (o.wr_cyc !== MEM_LAT + 2 || o.wdata !== 32'h112233AA) begin n_fail++; $display("FAIL byte_write: got %h at %0d, need 112233aa at %0d", o.wdata, o.wr_cyc, MEM_LAT + 2); end
    n_checks++; if (o.done_cyc !== MEM_LAT + 3) begin n_fail++; $display("FAIL byte_done: got cycle %0d, need %0d", o.done_cyc, MEM_LAT + 3); end
    ref_mem[32'h48 >> 2 & 15] = 32'h112233AA;
  endtask

  task automatic test_half();
    obs_t o;
    poke(32'h4C, 32'h11223344);
    do_store(2'b10, 32'h4C, 32'h0000BEEF, o);
    n_checks++; if (o.wdata !== 32'h1122BEEF || o.wr_n !== 1) begin n_fail++; $display("FAIL half_write: got %h n=%0d, need 1122beef n=1", o.wdata, o.wr_n); end
    n_checks++; if (o.ss_bad !== 1'b0) begin n_fail++; $display("FAIL half_ss_ctrl: got a busy cycle with ss_ctrl != 10, need 10 throughout"); end
    ref_mem[32'h4C >> 2 & 15] = 32'h1122BEEF;
  endtask

  task automatic test_align();
    obs_t o;
    logic mis;
    logic [31:0] exp_w;
    poke(32'h40, 32'hCAFEF00D);
    mis = model_mis(2'b10, 32'h41);
    exp_w = model_word(2'b10, 32'hCAFEF00D, 32'h0000BEEF);
    do_store(2'b10, 32'h41, 32'h0000BEEF, o);
    n_checks++; if (o.done_cyc !== model_done(2'b10, mis) || o.ae !== mis) begin n_fail++; $display("FAIL align_done: got done=%0d ae=%b, need done=%0d ae=%b", o.done_cyc, o.ae, model_done(2'b10, mis), mis); end
    n_checks++;
    if (mis ? (o.wr_n !== 0) : (o.wr_n !== 1 || o.wr_cyc !== MEM_LAT + 2 || o.wdata !== exp_w)) begin
      n_fail++; $display("FAIL align_write: got n=%0d cyc=%0d data=%h, need mis=%b data=%h", o.wr_n, o.wr_cyc, o.wdata, mis, exp_w);
    end
    if (!mis) ref_mem[0] = exp_w;
  endtask

  task automatic test_noop_back_to_back();
    obs_t o;
    poke(32'h54, 32'hA5A5A5A5);
    do_store(2'b00, 32'h54, 32'h12345678, o);
    n_checks++; if (o.done_cyc !== 1 || o.wr_n !== 0 || o.ae !== 1'b0) begin n_fail++; $display("FAIL noop: got done=%0d wr_n=%0d ae=%b, need 1 0 0", o.done_cyc, o.wr_n, o.ae); end
    do_store(2'b11, 32'h54, 32'h0000003C, o);
    n_checks++; if (o.done_cyc !== MEM_LAT + 3 || o.wdata !== 32'hA5A5A53C) begin n_fail++; $display("FAIL b2b_byte: got done=%0d data=%h, need %0d a5a5a53c", o.done_cyc, o.wdata, MEM_LAT + 3); end
    ref_mem[32'h54 >> 2 & 15] = 32'hA5A5A53C;
  endtask

  task automatic test_random();
    obs_t o;
    logic [1:0] sz;
    logic [31:0] a, b, exp_w;
    logic mis;
    int bad;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3)); a = $urandom_range(0, 63); b = $urandom;
      mis = model_mis(sz, a);
      exp_w = model_word(sz, ref_mem[a[5:2]], b);
      do_store(sz, a, b, o);
      n_checks++;
      if (o.done_cyc !== model_done(sz, mis) || o.ae !== mis || o.idle_after !== 1'b1 ||
          ((sz == 2'b00 || mis) ? (o.wr_n !== 0)
                                : (o.wr_n !== 1 || o.wr_cyc !== model_done(sz, mis) - 1 || o.wdata !== exp_w || o.waddr !== a))) begin
        n_fail++; bad++;
        $display("FAIL rand_store[%0d] sz=%b a=%h: got done=%0d ae=%b wr_n=%0d wr=%0d data=%h, need done=%0d ae=%b data=%h",
                 i, sz, a, o.done_cyc, o.ae, o.wr_n, o.wr_cyc, o.wdata, model_done(sz, mis), mis, exp_w);
      end
      if (sz != 2'b00 && !mis) ref_mem[a[5:2]] = exp_w;
    end
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (mem[k] !== ref_mem[k]) begin n_fail++; $display("FAIL rand_mem[%0d]: got %h, need %h", k, mem[k], ref_mem[k]); end
    end
  endtask

  task automatic test_reset_mid_op();
    int bad;
    poke(32'h58, 32'h0F0F0F0F);
    size = 2'b11; addr = 32'h58; bdata = 32'h55; start = 1'b1;
    tick();                                        // cycle 1: READ
    size = 2'b01; addr = 32'h0; start = 1'b1;      // must be ignored
    tick();
    start = 1'b0;
    n_checks++; if (ss_ctrl !== 2'b11 || mem_addr !== 32'h58 || !busy) begin n_fail++; $display("FAIL midop_ignore: got ss=%b ma=%h busy=%b, need 11 58 1", ss_ctrl, mem_addr, busy); end
    for (int c = 3; c <= MEM_LAT + 1; c++) tick();  // now in MERGE
    reset = 1'b1;
    tick();
    n_checks++;
    if ({mem_wr, done, busy, align_err} !== 4'b0 || mdr_q !== 0 || mem_wdata !== 0 || mem_addr !== 0 || ss_ctrl !== 2'b01) begin
      n_fail++;
      $display("FAIL midop_reset_values: got wr=%b done=%b busy=%b ae=%b mdr=%h wd=%h ma=%h ss=%b, need all 0 and ss=01",
               mem_wr, done, busy, align_err, mdr_q, mem_wdata, mem_addr, ss_ctrl);
    end
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (mem_wr || done || busy) bad++; end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midop_quiet: got %0d active cycles after reset, need 0", bad); end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin mem[k] = $urandom; ref_mem[k] = mem[k]; end
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_align();
    test_noop_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
